// File: rtl/accel_predecode_queue_if.sv
// Issue-side and dispatch-side handshake bundle of the vector predecode queue.
// The slave view belongs to the queue; the master view belongs to the issue/dispatch environment.
interface accel_predecode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_op;
    logic        out_vfp;
    logic        out_illegal;
    logic        out_cfg;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_rs1, out_rs2, out_rd,
        input  out_op, out_vfp, out_illegal, out_cfg
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_rs1, out_rs2, out_rd,
        output out_op, out_vfp, out_illegal, out_cfg
    );
endinterface

// File: rtl/accel_predecode_queue.sv
// Vector-instruction predecoder with an in-order FIFO between scalar issue and the vector dispatcher.
// Config entries (vset*/vector CSR) optionally fence dispatch until the backend acknowledges them.
module accel_predecode_queue #(
    parameter int unsigned Depth    = 4,
    parameter bit          CfgFence = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [1:0]              vs_i,
    input  logic [1:0]              fs_i,
    input  logic                    cfg_done_i,
    output logic                    drop_o,
    output logic [$clog2(Depth):0]  count_o,
    accel_predecode_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic        vfp;
        logic        illegal;
        logic        cfg;
    } entry_t;

    typedef struct packed {
        logic   accel;
        entry_t ent;
    } dec_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        WAIT_CFG = 1'b1
    } state_e;

    function automatic dec_t decode(input logic [31:0] ins, input logic [1:0] vs, input logic [1:0] fs);
        dec_t       d;
        logic       use_rs1;
        logic       use_rs2;
        logic       use_rd;
        logic       is_fs1;
        logic       is_fd;
        logic       is_load;
        logic       is_store;
        logic [3:0] mw;
        d        = {$bits(dec_t){1'b0}};
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        is_fs1   = 1'b0;
        is_fd    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        mw       = {ins[28], ins[14:12]};
        case (ins[6:0])
            7'h57: begin
                d.accel = 1'b1;
                case (ins[14:12])
                    3'b001: begin
                        d.ent.vfp = 1'b1;
                        is_fd     = (ins[31:26] == 6'b010000);
                        use_rd    = is_fd;
                    end
                    3'b010: use_rd = (ins[31:26] == 6'b010000);
                    3'b100, 3'b110: use_rs1 = 1'b1;
                    3'b101: begin
                        use_rs1   = 1'b1;
                        is_fs1    = 1'b1;
                        d.ent.vfp = 1'b1;
                    end
                    3'b111: begin
                        use_rd    = 1'b1;
                        use_rs1   = (ins[31:30] != 2'b11);
                        use_rs2   = (ins[31:25] == 7'b1000000);
                        d.ent.cfg = 1'b1;
                    end
                    default: use_rs1 = 1'b0;
                endcase
            end
            7'h07, 7'h27: begin
                // Only the vector element widths; the rest are scalar FP loads/stores.
                case (mw)
                    4'b0000, 4'b0101, 4'b0110, 4'b0111,
                    4'b1000, 4'b1101, 4'b1110, 4'b1111: d.accel = 1'b1;
                    default:                            d.accel = 1'b0;
                endcase
                use_rs1  = d.accel;
                use_rs2  = d.accel & (ins[27:26] == 2'b10);
                is_load  = d.accel & (ins[6:0] == 7'h07);
                is_store = d.accel & (ins[6:0] == 7'h27);
            end
            7'h73: begin
                if ((ins[14:12] != 3'b000) && (ins[14:12] != 3'b100)) begin
                    case (ins[31:20])
                        12'h008, 12'h009, 12'h00A, 12'h00F,
                        12'hC20, 12'hC21, 12'hC22: begin
                            d.accel   = 1'b1;
                            d.ent.cfg = 1'b1;
                            use_rs1   = 1'b1;
                            use_rs2   = 1'b1;
                            use_rd    = 1'b1;
                        end
                        default: d.accel = 1'b0;
                    endcase
                end else begin
                    d.accel = 1'b0;
                end
            end
            default: d.accel = 1'b0;
        endcase
        d.ent.instr = ins;
        d.ent.rs1   = use_rs1 ? ins[19:15] : 5'd0;
        d.ent.rs2   = use_rs2 ? ins[24:20] : 5'd0;
        d.ent.rd    = use_rd  ? ins[11:7]  : 5'd0;
        if (is_store) begin
            d.ent.op = 3'd4;
        end else if (is_load) begin
            d.ent.op = 3'd3;
        end else if (is_fs1) begin
            d.ent.op = 3'd1;
        end else if (is_fd) begin
            d.ent.op = 3'd2;
        end else begin
            d.ent.op = 3'd0;
        end
        d.ent.illegal = (vs == 2'b00) | (d.ent.vfp & (fs == 2'b00));
        return d;
    endfunction

    state_e         state_q;
    entry_t         mem_q [Depth];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [CW-1:0]  count_q;
    logic           drop_q;

    dec_t           dec_s;
    entry_t         head_s;
    logic           ready_s;
    logic           valid_s;
    logic           accept_s;
    logic           enq_s;
    logic           deq_s;

    // Decode the offered instruction and derive the handshake strobes.
    always_comb begin
        dec_s    = decode(bus.in_instr, vs_i, fs_i);
        head_s   = mem_q[rptr_q];
        ready_s  = (count_q < CW'(Depth));
        // Releasing the fence lets the head go out in the acknowledge cycle itself.
        valid_s  = (count_q != {CW{1'b0}}) && ((state_q == RUN) || cfg_done_i);
        accept_s = bus.in_valid && ready_s && !flush_i;
        enq_s    = accept_s && dec_s.accel;
        deq_s    = valid_s && bus.out_ready && !flush_i;
    end

    // FIFO storage, pointers, occupancy and the drop pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= {$bits(entry_t){1'b0}};
            end
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            drop_q  <= 1'b0;
        end else if (flush_i) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
            drop_q  <= 1'b0;
        end else begin
            if (enq_s) begin
                mem_q[wptr_q] <= dec_s.ent;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (deq_s) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(enq_s) - CW'(deq_s);
            drop_q  <= accept_s && !dec_s.accel;
        end
    end

    // Config fence: a dispatched config entry holds off the rest until cfg_done_i.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else if (flush_i) begin
            state_q <= RUN;
        end else if (CfgFence && deq_s && head_s.cfg) begin
            state_q <= WAIT_CFG;
        end else if ((state_q == WAIT_CFG) && cfg_done_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_q;
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.out_valid   = valid_s;
    assign bus.out_instr   = head_s.instr;
    assign bus.out_rs1     = head_s.rs1;
    assign bus.out_rs2     = head_s.rs2;
    assign bus.out_rd      = head_s.rd;
    assign bus.out_op      = head_s.op;
    assign bus.out_vfp     = head_s.vfp;
    assign bus.out_illegal = head_s.illegal;
    assign bus.out_cfg     = head_s.cfg;
    assign drop_o          = drop_q;
    assign count_o         = count_q;
endmodule
